// File: rtl/home_pkg.sv
// Shared definitions for the home event arbiter: source indices, FSM states
// and the display code helper.
package home_pkg;

  localparam int unsigned NUM_SRC = 6;
  localparam int unsigned SRC_W   = 3;

  localparam logic [SRC_W-1:0] SRC_FDOOR  = 3'd0;
  localparam logic [SRC_W-1:0] SRC_RDOOR  = 3'd1;
  localparam logic [SRC_W-1:0] SRC_ALARM  = 3'd2;
  localparam logic [SRC_W-1:0] SRC_WINDOW = 3'd3;
  localparam logic [SRC_W-1:0] SRC_HEATER = 3'd4;
  localparam logic [SRC_W-1:0] SRC_COOLER = 3'd5;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Display shows the granted source as index+1 so that 0 can mean idle
  function automatic logic [SRC_W-1:0] disp_code(input logic [SRC_W-1:0] idx);
    return SRC_W'(idx + SRC_W'(1));
  endfunction

endpackage

// File: rtl/rr_pick6.sv
// Combinational round-robin selector over six requesters: searches upward
// from last+1, wrapping modulo six.
module rr_pick6
  import home_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_pend,
  input  logic [SRC_W-1:0]   i_last,
  output logic               o_valid,
  output logic [SRC_W-1:0]   o_winner
);

  logic             w_found;
  logic [SRC_W:0]   w_sum;
  logic [SRC_W-1:0] w_idx;

  // First pending bit after the previous winner wins
  always_comb begin
    o_valid  = |i_pend;
    o_winner = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 1; k <= int'(NUM_SRC); k++) begin
      w_sum = {1'b0, i_last} + (SRC_W+1)'(k);
      if (w_sum >= (SRC_W+1)'(NUM_SRC)) begin
        w_sum = w_sum - (SRC_W+1)'(NUM_SRC);
      end
      w_idx = w_sum[SRC_W-1:0];
      if (!w_found && i_pend[w_idx]) begin
        o_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/home_event_arbiter.sv
// Home event arbiter: captures rising edges of six home event conditions as
// pending flags and grants the shared actuator/display group round-robin,
// one source at a time, for HOLD_CYCLES cycles with one idle cycle between.
// Optional build macro ALARM_PREEMPT_EN: a pending fire alarm aborts any
// other grant and is served immediately.
module home_event_arbiter
  import home_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned T_LOW       = 50,
  parameter int unsigned T_HIGH      = 70
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       SFD,
  input  logic       SRD,
  input  logic       SFA,
  input  logic       SW,
  input  logic [6:0] ST,
  output logic       fdoor,
  output logic       rdoor,
  output logic       alarmbuzz,
  output logic       winbuzz,
  output logic       heater,
  output logic       cooler,
  output logic [2:0] display,
  output logic       busy,
  output logic [5:0] pend
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [6:0] LP_T_LOW  = 7'(T_LOW);
  localparam logic [6:0] LP_T_HIGH = 7'(T_HIGH);
  localparam logic [NUM_SRC-1:0] ALARM_BIT = NUM_SRC'(1) << SRC_ALARM;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [SRC_W-1:0]   r_last, w_last_nxt;
  logic [NUM_SRC-1:0] r_pend, r_req_prev;
  logic [NUM_SRC-1:0] r_act, w_act_nxt;
  logic [SRC_W-1:0]   r_disp, w_disp_nxt;
  logic               r_busy, w_busy_nxt;
  logic [NUM_SRC-1:0] w_req, w_edge, w_set, w_clr;
  logic               w_valid, w_preempt;
  logic [SRC_W-1:0]   w_winner;

  assign w_req  = {(ST > LP_T_HIGH), (ST < LP_T_LOW), SW, SFA, SRD, SFD};
  assign w_edge = w_req & ~r_req_prev;

`ifdef ALARM_PREEMPT_EN
  assign w_preempt = (r_state == SERVE) && (r_disp != disp_code(SRC_ALARM)) &&
                     (r_pend[SRC_ALARM] || w_edge[SRC_ALARM]);
`else
  assign w_preempt = 1'b0;
`endif

  rr_pick6 u_pick (
    .i_pend   (r_pend),
    .i_last   (r_last),
    .o_valid  (w_valid),
    .o_winner (w_winner)
  );

  // State, datapath and output registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_last     <= SRC_COOLER;
      r_pend     <= '0;
      r_req_prev <= '0;
      r_act      <= '0;
      r_disp     <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_last     <= w_last_nxt;
      r_pend     <= (r_pend & ~w_clr) | w_set;
      r_req_prev <= w_req;
      r_act      <= w_act_nxt;
      r_disp     <= w_disp_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Next-state: leave IDLE on any pending source, leave SERVE when the hold expires
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_state_nxt = SERVE;
      SERVE:   if (!w_preempt && (r_cnt == '0)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next outputs, hold counter, last grant and pending set/clear masks
  always_comb begin
    w_act_nxt  = r_act;
    w_disp_nxt = r_disp;
    w_busy_nxt = r_busy;
    w_cnt_nxt  = r_cnt;
    w_last_nxt = r_last;
    w_clr      = '0;
    w_set      = w_edge;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_act_nxt  = NUM_SRC'(1) << w_winner;
          w_disp_nxt = disp_code(w_winner);
          w_busy_nxt = 1'b1;
          w_cnt_nxt  = HOLD_LAST;
          w_last_nxt = w_winner;
          w_clr      = NUM_SRC'(1) << w_winner;
        end else begin
          w_act_nxt  = '0;
          w_disp_nxt = '0;
          w_busy_nxt = 1'b0;
        end
      end
      SERVE: begin
        if (w_preempt) begin
          // Alarm takes over directly; its triggering edge is consumed by this grant
          w_act_nxt  = ALARM_BIT;
          w_disp_nxt = disp_code(SRC_ALARM);
          w_cnt_nxt  = HOLD_LAST;
          w_last_nxt = SRC_ALARM;
          w_clr      = ALARM_BIT;
          w_set      = w_edge & ~ALARM_BIT;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_act_nxt  = '0;
          w_disp_nxt = '0;
          w_busy_nxt = 1'b0;
        end
      end
      default: begin
        w_act_nxt  = '0;
        w_disp_nxt = '0;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign fdoor     = r_act[SRC_FDOOR];
  assign rdoor     = r_act[SRC_RDOOR];
  assign alarmbuzz = r_act[SRC_ALARM];
  assign winbuzz   = r_act[SRC_WINDOW];
  assign heater    = r_act[SRC_HEATER];
  assign cooler    = r_act[SRC_COOLER];
  assign display   = r_disp;
  assign busy      = r_busy;
  assign pend      = r_pend;

endmodule
